// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_pkg
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_t : sequencer state (IDLE, RUN, DONE)
//   OP_ADD  : op_sub encoding for A + B
//   OP_SUB  : op_sub encoding for A - B
// -----------------------------------------------------------------------------
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Operand/result bundle between the operand logic (master) and the serial
// add/subtract sequencer (slave).
//   start    : master -> slave, request, sampled only while the slave is idle
//   op_sub   : master -> slave, 0 = A+B, 1 = A-B, sampled with start
//   a_in     : master -> slave, operand A, sampled with start
//   b_in     : master -> slave, operand B, sampled with start
//   busy     : slave -> master, high from the cycle after acceptance through
//              the done cycle
//   done     : slave -> master, one-cycle pulse, results valid from then on
//   result   : slave -> master, registered sum/difference
//   cout     : slave -> master, final carry (subtract: 1 = no borrow)
//   overflow : slave -> master, signed overflow
//
// Handshake: a request is taken on the rising edge where the slave is idle
// and start=1; operands are captured on that same edge. While busy=1 start
// is ignored (no queueing). done pulses once per accepted request, and the
// earliest next acceptance is the edge after done drops.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op_sub, a_in, b_in,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op_sub, a_in, b_in,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// fullAdder
// Single-bit full-adder cell shared by the serial datapath.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
// -----------------------------------------------------------------------------
module fullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// WIDTH-bit add/subtract computed one bit per clock, LSB first, through a
// single full-adder cell. Subtraction is A + ~B + 1: B is inverted at
// acceptance and the carry flop is preloaded with 1.
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   bus         : operand/result handshake (slave side)
//   o_dbg_state : current sequencer state, for observation only
// Timing: accept edge T0, bit edges T1..TWIDTH, done/DONE in the cycle after
// TWIDTH, IDLE again after TWIDTH+1.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus,
  output state_t             o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum;
  logic             w_cell_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_sh_nxt;

  fullAdder u_cell (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cell_cout)
  );

  // The cycle processing the MSB; its cell outputs are the final results.
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the top so after WIDTH shifts bit 0 is at the LSB.
  assign w_sum_sh_nxt = {w_sum, r_sum_sh[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:                   w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh   <= bus.a_in;
            r_b_sh   <= (bus.op_sub == OP_SUB) ? ~bus.b_in : bus.b_in;
            r_carry  <= (bus.op_sub == OP_SUB);
            r_cnt    <= '0;
            r_sum_sh <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_sh_nxt;
          r_carry  <= w_cell_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_sum_sh_nxt;
            r_cout   <= w_cell_cout;
            // Signed overflow: carry into the MSB differs from carry out.
            r_ovf    <= r_carry ^ w_cell_cout;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  import serial_alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
  state_t dbg8, dbg16;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .o_dbg_state(dbg8)
  );
  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .o_dbg_state(dbg16)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {overflow, cout, result[15:0]}
  logic [17:0] exp_q[$];

  // ---------------- reference model ----------------
  // Plain integer arithmetic: result modulo 2^w, carry = unsigned carry
  // (subtract: no borrow), overflow = true signed result out of range.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic op);
    longint m, ua, ub, full, res, sa, sb, sv;
    logic co, ov;
    m    = longint'(1) << w;
    ua   = longint'(a);
    ub   = longint'(b);
    full = op ? ua - ub : ua + ub;
    res  = ((full % m) + m) % m;
    co   = op ? (ua >= ub) : (full >= m);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    sv   = op ? sa - sb : sa + sb;
    ov   = (sv >= m / 2) || (sv < -(m / 2));
    return {ov, co, 16'(res)};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one request in the next cycle, scrambles operands while busy,
  // and returns at the negedge where done is seen (lat = -1 on timeout).
  task automatic drive_op8(input logic [7:0] a, input logic [7:0] b, input logic op,
                           output int lat, output int busy_cnt, output int res_chg);
    logic [7:0] prev;
    prev = bus8.result;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.op_sub = op;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.op_sub = 1'($urandom);
    lat = 1; busy_cnt = 0; res_chg = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.result !== prev) res_chg++;
      @(negedge clk);
      lat++;
    end
    if (bus8.done) begin
      if (bus8.busy) busy_cnt++;
    end else lat = -1;
  endtask

  task automatic drive_op16(input logic [15:0] a, input logic [15:0] b, input logic op,
                            output int lat);
    @(negedge clk);
    bus16.start = 1'b1; bus16.a_in = a; bus16.b_in = b; bus16.op_sub = op;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a_in = 16'($urandom); bus16.b_in = 16'($urandom); bus16.op_sub = 1'($urandom);
    lat = 1;
    while (!bus16.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!bus16.done) lat = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus8.done); end
    checks++; if (bus8.result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h exp 00", bus8.result); end
    checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b exp 0", bus8.cout); end
    checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", bus8.overflow); end
    checks++; if (dbg8 !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg8, IDLE); end
    checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b exp 0", bus16.busy); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h3C, 8'hFF, 8'h05, 8'h80};
    logic [7:0] tb_[4] = '{8'h45, 8'h01, 8'h07, 8'h01};
    logic       to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] er [4] = '{8'h81, 8'h00, 8'hFE, 8'h7F};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat, bc, rc;
    for (int i = 0; i < 4; i++) begin
      drive_op8(ta[i], tb_[i], to[i], lat, bc, rc);
      checks++; if (lat != 9) begin errors++; $display("FAIL dir%0d_latency: got %0d exp 9", i, lat); end
      checks++; if (bc != 9) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d exp 9", i, bc); end
      checks++; if (rc != 0) begin errors++; $display("FAIL dir%0d_result_stable: got %0d changes exp 0", i, rc); end
      checks++; if (bus8.result !== er[i]) begin errors++; $display("FAIL dir%0d_result: got %h exp %h", i, bus8.result, er[i]); end
      checks++; if (bus8.cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout: got %b exp %b", i, bus8.cout, ec[i]); end
      checks++; if (bus8.overflow !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b exp %b", i, bus8.overflow, eo[i]); end
      checks++; if (dbg8 !== DONE) begin errors++; $display("FAIL dir%0d_done_state: got %0d exp %0d", i, dbg8, DONE); end
      @(negedge clk);
      checks++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse_end: got done=%b busy=%b exp 0/0", i, bus8.done, bus8.busy); end
      checks++; if (bus8.result !== er[i]) begin errors++; $display("FAIL dir%0d_result_hold: got %h exp %h", i, bus8.result, er[i]); end
    end
  endtask

  task automatic test_ignored_start();
    int k;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.op_sub = OP_ADD;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 1;
    while (!bus8.done && k < 40) begin
      if (k == 3) begin
        bus8.start = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.op_sub = OP_ADD;
      end else bus8.start = 1'b0;
      @(negedge clk);
      k++;
    end
    checks++; if (k != 9) begin errors++; $display("FAIL ign_latency: got %0d exp 9", k); end
    checks++; if (bus8.result !== 8'h30) begin errors++; $display("FAIL ign_result: got %h exp 30", bus8.result); end
    // start during DONE: ignored, held into the following IDLE cycle
    bus8.start = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.op_sub = OP_ADD;
    @(negedge clk);
    checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL ign_done_cycle_start: got busy=%b done=%b exp 0/0", bus8.busy, bus8.done); end
    @(negedge clk);
    bus8.start = 1'b0;
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL ign_idle_accept: got busy=%b exp 1", bus8.busy); end
    checks++; if (bus8.result !== 8'h30) begin errors++; $display("FAIL ign_result_hold: got %h exp 30", bus8.result); end
    k = 1;
    while (!bus8.done && k < 40) begin @(negedge clk); k++; end
    checks++; if (k != 9) begin errors++; $display("FAIL ign2_latency: got %0d exp 9", k); end
    checks++; if (bus8.result !== 8'hFF || bus8.cout !== 1'b0 || bus8.overflow !== 1'b0)
      begin errors++; $display("FAIL ign2_result: got %h/%b/%b exp ff/0/0", bus8.result, bus8.cout, bus8.overflow); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k, bad;
    int lat, bc, rc;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h11; bus8.b_in = 8'h22; bus8.op_sub = OP_ADD;
    @(negedge clk);
    bus8.start = 1'b0;
    for (k = 1; k < 4; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", bus8.busy); end
    checks++; if (bus8.result !== 8'h00 || bus8.cout !== 1'b0 || bus8.overflow !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs: got %h/%b/%b exp 00/0/0", bus8.result, bus8.cout, bus8.overflow); end
    bad = 0;
    repeat (3) begin @(negedge clk); if (bus8.done !== 1'b0) bad++; end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.result !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bad cycles exp 0", bad); end
    drive_op8(8'h01, 8'h01, OP_ADD, lat, bc, rc);
    checks++; if (lat != 9) begin errors++; $display("FAIL rstmid_after_latency: got %0d exp 9", lat); end
    checks++; if (bus8.result !== 8'h02) begin errors++; $display("FAIL rstmid_after_result: got %h exp 02", bus8.result); end
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic op;
    logic [17:0] e;
    int lat, bc, rc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_model(8, {8'h00, a}, {8'h00, b}, op));
      drive_op8(a, b, op, lat, bc, rc);
      e = exp_q.pop_front();
      checks++; if (lat != 9) begin errors++; $display("FAIL rnd8_latency[%0d]: got %0d exp 9", i, lat); end
      checks++; if ({bus8.overflow, bus8.cout, bus8.result} !== {e[17:16], e[7:0]})
        begin errors++; $display("FAIL rnd8[%0d] %h %s %h: got ov/co/res %b/%b/%h exp %b/%b/%h", i, a, op ? "-" : "+", b,
                                 bus8.overflow, bus8.cout, bus8.result, e[17], e[16], e[7:0]); end
      checks++; if (rc != 0) begin errors++; $display("FAIL rnd8_stable[%0d]: got %0d changes exp 0", i, rc); end
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b;
    logic op;
    logic [17:0] e;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom_range(0, 1));
      if (i < 4) begin a = 16'h7FFF; b = 16'(i); end
      exp_q.push_back(ref_model(16, a, b, op));
      drive_op16(a, b, op, lat);
      e = exp_q.pop_front();
      checks++; if (lat != 17) begin errors++; $display("FAIL rnd16_latency[%0d]: got %0d exp 17", i, lat); end
      checks++; if ({bus16.overflow, bus16.cout, bus16.result} !== e)
        begin errors++; $display("FAIL rnd16[%0d] %h %s %h: got ov/co/res %b/%b/%h exp %b/%b/%h", i, a, op ? "-" : "+", b,
                                 bus16.overflow, bus16.cout, bus16.result, e[17], e[16], e[15:0]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus8.start = 1'b0;  bus8.op_sub = 1'b0;  bus8.a_in = '0;  bus8.b_in = '0;
    bus16.start = 1'b0; bus16.op_sub = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random8();
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
